// File: rtl/ahb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_arb_pkg
//
// Shared definitions for the AHB bus arbiter:
//   trans_e      - HTRANS encoding of the granted master
//   burst_e      - HBURST encoding of the granted master
//   arb_state_e  - arbiter state machine encoding
//   CNT_W        - width of the fixed-length burst beat counter
//   burst_beats  - number of beats in a burst (0 = undefined length)
//   is_fixed_burst - true for the counted burst types (4, 8 or 16 beats)
// ---------------------------------------------------------------------------
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } trans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } burst_e;

  // PARK: nobody requests, master 0 holds the bus by default.
  // OWN: owner doing SINGLE or undefined-length INCR transfers.
  // BURST: owner inside a fixed-length burst, beats being counted.
  // LOCK: owner holds a locked sequence, no rearbitration.
  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_LOCK  = 2'd3
  } arb_state_e;

  // Largest fixed burst is 16 beats, so the counter holds up to 15.
  localparam int CNT_W = 4;

  // Beats per burst; undefined-length INCR reports 0.
  function automatic logic [4:0] burst_beats(input burst_e b);
    logic [4:0] beats;
    beats = 5'd1;
    unique case (b)
      BURST_SINGLE:              beats = 5'd1;
      BURST_INCR:                beats = 5'd0;
      BURST_WRAP4,  BURST_INCR4:  beats = 5'd4;
      BURST_WRAP8,  BURST_INCR8:  beats = 5'd8;
      BURST_WRAP16, BURST_INCR16: beats = 5'd16;
      default:                   beats = 5'd1;
    endcase
    return beats;
  endfunction

  // Bursts whose length is known up front and therefore counted.
  function automatic logic is_fixed_burst(input burst_e b);
    return (burst_beats(b) > 5'd1);
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// ---------------------------------------------------------------------------
// ahb_rr_picker
//
// Combinational round-robin picker. Starting at (last_id + 1) mod
// AHB_MASTERS and wrapping around, the first master with its request bit set
// wins. A master that is the only requester wins against itself after the
// full wrap.
//
// Ports:
//   req     in   AHB_MASTERS  request vector
//   last_id in   ID_W         index of the previous bus owner
//   winner  out  AHB_MASTERS  one-hot winner (all zero when valid = 0)
//   valid   out  1            at least one master requests
// ---------------------------------------------------------------------------
module ahb_rr_picker
  import ahb_arb_pkg::*;
#(
  parameter int AHB_MASTERS = 4,
  parameter int ID_W        = $clog2(AHB_MASTERS)
) (
  input  logic [AHB_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        last_id,
  output logic [AHB_MASTERS-1:0] winner,
  output logic                   valid
);

  // Walk the masters in priority order beginning just after the last owner;
  // once a winner is found the remaining candidates are ignored.
  always_comb begin
    int cand;
    winner = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= AHB_MASTERS; i++) begin
      cand = (int'(last_id) + i) % AHB_MASTERS;
      if (!valid && req[cand[ID_W-1:0]]) begin
        winner[cand[ID_W-1:0]] = 1'b1;
        valid                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
//
// Round-robin AHB bus arbiter with bus parking, fixed-length burst tracking
// and locked-sequence support. Ownership only changes on a rising clock edge
// with ready high; ready low freezes everything.
//
// Ports:
//   clk        in   1            bus clock
//   rstn       in   1            synchronous active-low reset
//   req        in   AHB_MASTERS  per-master bus request
//   lock       in   AHB_MASTERS  per-master lock request (only counts with req)
//   trans      in   2            HTRANS of the granted master
//   burst      in   3            HBURST of the granted master
//   ready      in   1            HREADY from the slave multiplexer
//   grant      out  AHB_MASTERS  one-hot address-phase grant
//   master_id  out  ID_W         index of the address-phase owner
//   data_id    out  ID_W         index of the data-phase owner
//   locked     out  1            owner holds a locked sequence
// ---------------------------------------------------------------------------
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int AHB_MASTERS = 4,
  parameter int ID_W        = $clog2(AHB_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [AHB_MASTERS-1:0] req,
  input  logic [AHB_MASTERS-1:0] lock,
  input  logic [1:0]             trans,
  input  logic [2:0]             burst,
  input  logic                   ready,
  output logic [AHB_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        master_id,
  output logic [ID_W-1:0]        data_id,
  output logic                   locked
);

  localparam logic [AHB_MASTERS-1:0] PARK_GRANT = AHB_MASTERS'(1);
  // Last owner after reset is the highest index so master 0 wins first.
  localparam logic [ID_W-1:0]        LAST_RESET = ID_W'(AHB_MASTERS - 1);

  arb_state_e             state_q,   state_d;
  logic [AHB_MASTERS-1:0] grant_q,   grant_d;
  logic [ID_W-1:0]        owner_q,   owner_d;
  logic [ID_W-1:0]        data_id_q, data_id_d;
  logic                   locked_q,  locked_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [ID_W-1:0]        last_q,    last_d;

  trans_e                 trans_t;
  burst_e                 burst_t;
  logic [AHB_MASTERS-1:0] lock_eff;
  logic [AHB_MASTERS-1:0] win_onehot;
  logic                   win_valid;
  logic [ID_W-1:0]        win_id;

  assign trans_t  = trans_e'(trans);
  assign burst_t  = burst_e'(burst);
  assign lock_eff = lock & req;

  ahb_rr_picker #(
    .AHB_MASTERS (AHB_MASTERS),
    .ID_W        (ID_W)
  ) u_picker (
    .req     (req),
    .last_id (last_q),
    .winner  (win_onehot),
    .valid   (win_valid)
  );

  // Binary index of the picker's one-hot winner.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < AHB_MASTERS; i++) begin
      if (win_onehot[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  // State register. Reset aborts any burst or lock in progress at once.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_PARK;
      grant_q   <= PARK_GRANT;
      owner_q   <= '0;
      data_id_q <= '0;
      locked_q  <= 1'b0;
      cnt_q     <= '0;
      last_q    <= LAST_RESET;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      data_id_q <= data_id_d;
      locked_q  <= locked_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  // Next-state logic. Each state decides whether this accepted cycle is an
  // arbitration point; the shared block at the end then hands the bus to the
  // round-robin winner, or parks it on master 0 when nobody requests. Because
  // the picker sees the current req vector, an owner dropping its request
  // while another raises one hands over directly with no PARK cycle.
  always_comb begin
    logic       arb;
    logic [4:0] beats_m1;

    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    data_id_d = data_id_q;
    locked_d  = locked_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    arb       = 1'b0;
    beats_m1  = burst_beats(burst_t) - 5'd1;

    if (ready) begin
      // The address phase just accepted becomes the data phase.
      data_id_d = owner_q;

      unique case (state_q)
        ST_PARK: begin
          arb = 1'b1;
        end

        ST_OWN: begin
          if (trans_t == TRANS_IDLE) begin
            arb = 1'b1;
          end else if (burst_t == BURST_INCR && !req[owner_q]) begin
            arb = 1'b1;
          end else if (trans_t == TRANS_NONSEQ && is_fixed_burst(burst_t)) begin
            // The NONSEQ is the first beat, so beats-1 SEQs remain.
            state_d = ST_BURST;
            cnt_d   = beats_m1[CNT_W-1:0];
          end
        end

        ST_BURST: begin
          unique case (trans_t)
            TRANS_IDLE, TRANS_NONSEQ: arb = 1'b1;
            TRANS_SEQ: begin
              // A SEQ taking the counter to zero is the last beat.
              if (cnt_q <= CNT_W'(1)) begin
                arb = 1'b1;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
            TRANS_BUSY: ;
            default: ;
          endcase
        end

        ST_LOCK: begin
          // Other requests are ignored until the owner releases the lock
          // and the bus goes idle.
          if (!lock_eff[owner_q] && trans_t == TRANS_IDLE) begin
            arb = 1'b1;
          end
        end

        default: begin
          arb = 1'b1;
        end
      endcase

      if (arb) begin
        // A new tenure always starts from a clean beat count.
        cnt_d = '0;
        if (win_valid) begin
          grant_d  = win_onehot;
          owner_d  = win_id;
          last_d   = win_id;
          locked_d = lock_eff[win_id];
          state_d  = lock_eff[win_id] ? ST_LOCK : ST_OWN;
        end else begin
          grant_d  = PARK_GRANT;
          owner_d  = '0;
          locked_d = 1'b0;
          state_d  = ST_PARK;
        end
      end
    end
  end

  assign grant     = grant_q;
  assign master_id = owner_q;
  assign data_id   = data_id_q;
  assign locked    = locked_q;

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter AHB_MASTERS, default 4, number of requesting masters; legal range 2..8.
REQ-002 Parameter ID_W, default $clog2(AHB_MASTERS), width of master index outputs.
REQ-003 Port clk  input  1  bus clock; all state updates on its rising edge.
REQ-004 Port rstn  input  1  reset, synchronous and active-low.
REQ-005 Port req  input  AHB_MASTERS  per-master bus request.
REQ-006 Port lock  input  AHB_MASTERS  per-master locked-sequence request, qualified by req.
REQ-007 Port trans  input  2  trans of the granted master (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-008 Port burst  input  3  burst of the granted master (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
REQ-009 Port ready  input  1  bus ready from the slave multiplexer.
REQ-010 Port grant  output  AHB_MASTERS  one-hot address-phase grant.
REQ-011 Port master_id  output  ID_W  binary index of the address-phase owner; drives the address/control mux.
REQ-012 Port data_id  output  ID_W  binary index of the data-phase owner; drives the wdata mux.
REQ-013 Port locked  output  1  current owner holds a locked sequence.

Function
REQ-014 States: PARK (no requester; grant master 0), OWN (owner, SINGLE or undefined-length INCR), BURST (fixed-length burst counting), LOCK (locked owner).
REQ-015 Grant, master_id and locked change only on a rising edge with ready=1; ready=0 freezes all state, outputs and the beat counter.
REQ-016 Arbitration point when ready=1 and any of: state PARK; OWN with trans=IDLE; OWN with burst=INCR and owner req=0; BURST with final beat accepted; LOCK with owner lock=0 and trans=IDLE.
REQ-017 At an arbitration point, winner is the first master with req=1 searching round-robin from (last owner+1) mod AHB_MASTERS; no requester -> PARK.
REQ-018 Winner with lock=1 -> LOCK; otherwise OWN.
REQ-019 OWN, trans=NONSEQ accepted (ready=1), burst in {WRAP4,INCR4,WRAP8,INCR8,WRAP16,INCR16} -> BURST, counter loaded with beats-1 (3, 7 or 15).
REQ-020 BURST: counter decrements on each accepted SEQ; BUSY does not decrement; counter reaching 0 with an accepted SEQ is the final beat.
REQ-021 BURST: trans=IDLE or NONSEQ accepted before counter=0 (early termination) is an arbitration point.
REQ-022 LOCK: no other master is granted while owner lock=1, regardless of other requests.
REQ-023 data_id loads master_id on every rising edge with ready=1; holds otherwise.
REQ-024 grant always one-hot; master_id always equals the index of the set grant bit.
REQ-025 Simultaneous req deassertion by owner and req assertion by others at an arbitration point: new owner chosen in the same cycle, no PARK cycle inserted.
REQ-026 Owner remaining sole requester at an arbitration point is re-granted (round-robin wraps to itself).

Reset
REQ-027 rstn=0 at a rising edge: state PARK, grant=1 (master 0), master_id=0, data_id=0, locked=0, counter=0, last owner=AHB_MASTERS-1 (so master 0 wins first); reset mid-burst or mid-lock aborts immediately.

Structure
REQ-028 Shared package ahb_arb_pkg holds trans and burst enums, state enum, and a beats-per-burst function.
REQ-029 One combinational sub-module ahb_rr_picker (req vector, last owner -> one-hot winner, valid); the state machine and counter live in ahb_arbiter.

Verification
REQ-030 Reset, req=4'b0000 -> grant=4'b0001, master_id=0, state PARK; req=4'b0100, ready=1 -> next cycle grant=4'b0100.
REQ-031 Masters 1 and 3 constant req, SINGLE NONSEQ then IDLE each -> grants alternate 1,3,1,3.
REQ-032 Master 2 INCR8 NONSEQ, master 0 requesting, ready=1 -> grant held 8 accepted beats, moves to master 0 after eighth; 2 ready=0 cycles mid-burst extend hold by 2.
REQ-033 Master 1 lock=1, masters 0/2 requesting, 5 SINGLE transfers -> grant stays 4'b0010, locked=1; lock drop with IDLE -> master 2 granted.
REQ-034 INCR16 terminated by IDLE after 5 beats -> rearbitration that cycle; counter not carried to next owner.
REQ-035 rstn=0 mid-WRAP4 on master 3 -> next cycle grant=4'b0001, data_id=0, locked=0.
